// File: rtl/rom_pkg.sv
// ---------------------------------------------------------------------------
// rom_pkg -- shared constants for the AZPR instruction ROM.
//
// Holds the default geometry (address width, word width, depth), the reset
// level (active-low) and the base value of the built-in image. The helper
// function builtin_word() produces the built-in image word for an address.
// ---------------------------------------------------------------------------
package rom_pkg;

    localparam int          ROM_ADDR_W     = 11;
    localparam int          WORD_DATA_W    = 32;
    localparam int          ROM_DEPTH      = 2048;

    // Level of the reset input that holds the block in reset.
    localparam logic        RST_ACTIVE     = 1'b0;

    // Built-in image: every word is this base OR'ed with its own address.
    localparam logic [31:0] ROM_IMAGE_BASE = 32'hA5A5_0000;

    function automatic logic [31:0] builtin_word(input logic [31:0] a);
        return ROM_IMAGE_BASE | a;
    endfunction

endpackage

// File: rtl/rom_mem_array.sv
// ---------------------------------------------------------------------------
// rom_mem_array -- storage array of the AZPR ROM with unregistered lookup.
//
// Configuration macro: ROM_INIT_FILE_EN
//   defined   : contents come from the file image table (one word per entry,
//               address 0 upward); unlisted words are zero.
//   undefined : contents are the built-in image word(a) = A5A5_0000 | a.
//
// Ports:
//   addr    in  ADDR_W  word address (caller guarantees range, see azpr_rom)
//   rd_data out DATA_W  combinational read of the array at addr
//
// There is no handshake: the lookup is purely combinational and the caller
// registers it.
// ---------------------------------------------------------------------------
module rom_mem_array
    import rom_pkg::*;
#(
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int DATA_W    = WORD_DATA_W,
    parameter int DEPTH     = ROM_DEPTH,
    parameter     INIT_FILE = "rom.hex"
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rd_data
);

    // Index width covers exactly the stored words; the upper address bits
    // are only meaningful to the range check in the parent.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;

    assign idx = addr[IDX_W-1:0];

`ifdef ROM_INIT_FILE_EN
    localparam int          FILE_WORDS = 2;
    localparam logic [31:0] FILE_IMAGE [FILE_WORDS] = '{
        32'hDEAD_BEEF,
        32'h1234_5678
    };

    // Clear first so words not listed in the image read as zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
        end
        for (int i = 0; i < FILE_WORDS; i++) begin
            if (i < DEPTH) begin
                mem[i] = DATA_W'(FILE_IMAGE[i]);
            end
        end
    end
`else
    for (genvar i = 0; i < DEPTH; i++) begin : g_image
        assign mem[i] = DATA_W'(builtin_word(32'(i)));
    end
`endif

    assign rd_data = mem[idx];

endmodule

// File: rtl/azpr_rom.sv
// ---------------------------------------------------------------------------
// azpr_rom -- read-only word memory with a one-cycle registered read.
//
// Configuration macro: ROM_INIT_FILE_EN (selects file image vs built-in
// image, handled inside rom_mem_array).
//
// Ports:
//   clk    in  1       single clock, rising edge
//   reset  in  1       asynchronous, active-low; forces dout to zero
//   addr   in  ADDR_W  word address, sampled on every rising edge
//   dout   out DATA_W  registered read data, valid one cycle after addr
//
// No handshake: a read happens on every edge out of reset, so consecutive
// addresses produce one word per cycle with no bubbles.
// ---------------------------------------------------------------------------
module azpr_rom
    import rom_pkg::*;
#(
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int DATA_W    = WORD_DATA_W,
    parameter int DEPTH     = ROM_DEPTH,
    parameter     INIT_FILE = "rom.hex"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] rd_data;
    logic              in_range;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;

    rom_mem_array #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .addr    (addr),
        .rd_data (rd_data)
    );

    // Addresses past the stored words read as zero rather than wrapping.
    always_comb begin
        in_range = ({1'b0, addr} < DEPTH_LIM);
        dout_d   = in_range ? rd_data : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (reset == RST_ACTIVE) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_azpr_rom.sv
// ---------------------------------------------------------------------------
// tb_azpr_rom -- bench for azpr_rom with the built-in image.
//
// Two instances share clk/reset/addr: the default geometry (DEPTH 2048) and
// a shallow one (DEPTH 1024) whose upper half of the address space must read
// as zero. Addresses are driven on the falling edge; the expected words are
// queued at the same time and popped by a monitor just after the following
// rising edge. A second monitor checks that dout holds between edges.
// ---------------------------------------------------------------------------
module tb_azpr_rom;

    logic        clk;
    logic        reset;
    logic [10:0] addr;
    logic [31:0] dout;
    logic [31:0] dout2;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp2_q[$];
    logic [31:0] last_exp;
    logic [31:0] last_exp2;
    logic        have_last = 1'b0;
    logic [31:0] e1;
    logic [31:0] e2;

    azpr_rom u_dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .dout  (dout)
    );

    azpr_rom #(.DEPTH(1024)) u_dut_shallow (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .dout  (dout2)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog: the run is finite, this only guards against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // A stored word is the image base plus its address; past the depth the
    // ROM returns zero.
    function automatic logic [31:0] ref_word(input int a, input int depth);
        logic [31:0] w;
        if (a >= depth) begin
            w = 32'h0;
        end else begin
            w = 32'hA5A5_0000 + 32'(a);
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_push(input logic [10:0] a);
        addr = a;
        exp_q.push_back(ref_word(int'(a), 2048));
        exp2_q.push_back(ref_word(int'(a), 1024));
    endtask

    task automatic issue(input logic [10:0] a);
        @(negedge clk);
        drive_push(a);
    endtask

    // Start a read, then pull reset low before the edge that would capture
    // it. dout must clear at once and stay clear; the release edge carries a
    // fresh read so the first post-reset word is checked too.
    task automatic reset_pulse(input int cycles);
        @(negedge clk);
        drive_push(11'($urandom_range(0, 2047)));
        #2;
        reset = 1'b0;
        exp_q.delete();
        exp2_q.delete();
        have_last = 1'b0;
        #1;
        check("async_rst_d2048", dout, 32'h0);
        check("async_rst_d1024", dout2, 32'h0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("in_rst_d2048", dout, 32'h0);
            check("in_rst_d1024", dout2, 32'h0);
            addr = 11'($urandom_range(0, 2047));
        end
        @(negedge clk);
        reset = 1'b1;
        drive_push(11'($urandom_range(0, 2047)));
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            have_last = 1'b0;
        end else if (exp_q.size() > 0) begin
            e1 = exp_q.pop_front();
            e2 = exp2_q.pop_front();
            check("read_d2048", dout, e1);
            check("read_d1024", dout2, e2);
            last_exp  = e1;
            last_exp2 = e2;
            have_last = 1'b1;
        end
    end

    // Half a cycle later the address has already moved on; dout must not.
    always @(negedge clk) begin
        #1;
        if (reset && have_last) begin
            check("hold_d2048", dout, last_exp);
            check("hold_d1024", dout2, last_exp2);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [10:0] corner [4];
        corner[0] = 11'h000;
        corner[1] = 11'h3FF;
        corner[2] = 11'h400;
        corner[3] = 11'h7FF;

        // Reset held for three edges with addr = 5.
        reset = 1'b0;
        addr  = 11'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("por_d2048", dout, 32'h0);
            check("por_d1024", dout2, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        drive_push(11'd5);

        // Consecutive reads including the top address.
        issue(11'd0);
        issue(11'd1);
        issue(11'd2);
        issue(11'h7FF);

        // Address wiggles between edges; only the value at the edge counts.
        @(negedge clk);
        addr = 11'd3;
        #1 addr = 11'd9;
        #1 addr = 11'd3;
        exp_q.push_back(ref_word(3, 2048));
        exp2_q.push_back(ref_word(3, 1024));
        @(negedge clk);
        addr = 11'd9;
        #2 addr = 11'd3;
        exp_q.push_back(ref_word(3, 2048));
        exp2_q.push_back(ref_word(3, 1024));

        // Shallow-depth boundary.
        issue(11'h400);
        issue(11'h3FF);
        issue(11'h400);

        // Reset in the middle of a read stream.
        issue(11'd100);
        issue(11'd101);
        reset_pulse(2);
        issue(11'd102);
        issue(11'd103);

        // Random stream with corner addresses and occasional reset pulses.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset_pulse(int'($urandom_range(1, 3)));
            end else if ($urandom_range(0, 4) == 0) begin
                issue(corner[$urandom_range(0, 3)]);
            end else begin
                issue(11'($urandom_range(0, 2047)));
            end
        end

        // Let the last read drain, then make sure nothing was left unchecked.
        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
